rv32i_mc_control_unit: RTL and testbench

Multi-cycle control unit for the RV32I core: a state machine that sequences fetch, decode, execute, memory and write-back, and issues the datapath selects and strobes per state. It decodes the same instruction classes as the single-cycle controller (R, I, IL, S, B, LUI, AUIPC, JAL, JALR). It adds ready-handshaked instruction and data memory, an optional bus timeout, illegal-opcode trapping and a retire pulse. It sits between the instruction register / memory interfaces and the existing datapath (regfile, ALU, PC, load/store size unit).

---
 rtl/rv32i_ctrl_pkg.sv | 36 +++
 rtl/rv32i_decoder.sv | 95 +++++++++
 rtl/rv32i_mc_control_unit.sv | 169 ++++++++++++++++
 tb/tb_rv32i_mc_control_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// rtl/rv32i_ctrl_pkg.sv - shared opcodes, encodings and state types for the multi-cycle controller
package rv32i_ctrl_pkg;

   localparam logic [6:0] OP_R_TYPE     = 7'b0110011;
   localparam logic [6:0] OP_I_TYPE     = 7'b0010011;
   localparam logic [6:0] OP_IL_TYPE    = 7'b0000011;
   localparam logic [6:0] OP_S_TYPE     = 7'b0100011;
   localparam logic [6:0] OP_B_TYPE     = 7'b1100011;
   localparam logic [6:0] OP_LUI_TYPE   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC_TYPE = 7'b0010111;
   localparam logic [6:0] OP_JAL_TYPE   = 7'b1101111;
   localparam logic [6:0] OP_JALR_TYPE  = 7'b1100111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;
   localparam logic [3:0] ALU_SRA = 4'b1101;

   localparam logic [1:0] WSRC_ALU  = 2'b00;
   localparam logic [1:0] WSRC_LOAD = 2'b01;
   localparam logic [1:0] WSRC_IMM  = 2'b10;
   localparam logic [1:0] WSRC_PC4  = 2'b11;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_TRAP    = 3'd5
   } mc_state_e;

   typedef enum logic [3:0] {
      CL_R, CL_I, CL_IL, CL_S, CL_B, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_NONE
   } instr_class_e;

endpackage

// File: rtl/rv32i_decoder.sv
// rtl/rv32i_decoder.sv - combinational opcode decode to class, selects and ALU/size controls
module rv32i_decoder
   import rv32i_ctrl_pkg::*;
(
   input  logic [31:0]  instr_code,
   output instr_class_e cls,
   output logic         legal,
   output logic         alu_src_sel_1,
   output logic         alu_src_sel_2,
   output logic [1:0]   reg_w_src_sel,
   output logic [3:0]   alu_control,
   output logic [2:0]   size_control
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       f7b5;
   logic       unused_bits;

   assign opcode      = instr_code[6:0];
   assign funct3      = instr_code[14:12];
   assign f7b5        = instr_code[30];
   // register and immediate fields are consumed by the datapath, not here
   assign unused_bits = &{1'b0, instr_code[31], instr_code[29:15], instr_code[11:7]};

   // Opcode class lookup; sel_1 picks PC over rs1, sel_2 picks immediate over rs2
   always_comb begin
      cls           = CL_NONE;
      legal         = 1'b0;
      alu_src_sel_1 = 1'b0;
      alu_src_sel_2 = 1'b0;
      reg_w_src_sel = WSRC_ALU;
      alu_control   = ALU_ADD;
      size_control  = 3'b000;
      case (opcode)
         OP_R_TYPE: begin
            cls         = CL_R;
            legal       = 1'b1;
            alu_control = {f7b5, funct3};
         end
         OP_I_TYPE: begin
            cls           = CL_I;
            legal         = 1'b1;
            alu_src_sel_2 = 1'b1;
            // only the right shifts use bit 30 to pick arithmetic vs logical
            alu_control   = {(funct3 == 3'b101) & f7b5, funct3};
         end
         OP_IL_TYPE: begin
            cls           = CL_IL;
            legal         = 1'b1;
            alu_src_sel_2 = 1'b1;
            reg_w_src_sel = WSRC_LOAD;
            size_control  = funct3;
         end
         OP_S_TYPE: begin
            cls           = CL_S;
            legal         = 1'b1;
            alu_src_sel_2 = 1'b1;
            size_control  = funct3;
         end
         OP_B_TYPE: begin
            cls         = CL_B;
            legal       = 1'b1;
            alu_control = ALU_SUB;
         end
         OP_LUI_TYPE: begin
            cls           = CL_LUI;
            legal         = 1'b1;
            alu_src_sel_2 = 1'b1;
            reg_w_src_sel = WSRC_IMM;
         end
         OP_AUIPC_TYPE: begin
            cls           = CL_AUIPC;
            legal         = 1'b1;
            alu_src_sel_1 = 1'b1;
            alu_src_sel_2 = 1'b1;
         end
         OP_JAL_TYPE: begin
            cls           = CL_JAL;
            legal         = 1'b1;
            alu_src_sel_1 = 1'b1;
            alu_src_sel_2 = 1'b1;
            reg_w_src_sel = WSRC_PC4;
         end
         OP_JALR_TYPE: begin
            cls           = CL_JALR;
            legal         = 1'b1;
            alu_src_sel_2 = 1'b1;
            reg_w_src_sel = WSRC_PC4;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rv32i_mc_control_unit.sv
// rtl/rv32i_mc_control_unit.sv - multi-cycle RV32I sequencer with handshaked memories and traps
module rv32i_mc_control_unit
   import rv32i_ctrl_pkg::*;
#(
   parameter int BUS_TIMEOUT = 16,
   parameter bit DATA_WAIT   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_code,
   input  logic        i_ready,
   input  logic        d_ready,
   input  logic        btaken,
   output logic        i_req,
   output logic        ir_we,
   output logic        d_req,
   output logic        d_we,
   output logic        regfile_we,
   output logic        pc_we,
   output logic        alu_src_sel_1,
   output logic        alu_src_sel_2,
   output logic [1:0]  reg_w_src_sel,
   output logic [3:0]  alu_control,
   output logic [2:0]  size_control,
   output logic        branch,
   output logic        jal,
   output logic        instr_retired,
   output logic        illegal_instr,
   output logic        bus_err,
   output logic [2:0]  state_o
);

   localparam int CW = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;

   mc_state_e    state, nxt;
   logic [CW-1:0] cnt;
   logic          req_pending, req_ready, limit_hit;

   instr_class_e dec_cls;
   logic         dec_legal, dec_sel_1, dec_sel_2;
   logic [1:0]   dec_wsrc;
   logic [3:0]   dec_alu;
   logic [2:0]   dec_size;

   rv32i_decoder u_decoder (
      .instr_code    (instr_code),
      .cls           (dec_cls),
      .legal         (dec_legal),
      .alu_src_sel_1 (dec_sel_1),
      .alu_src_sel_2 (dec_sel_2),
      .reg_w_src_sel (dec_wsrc),
      .alu_control   (dec_alu),
      .size_control  (dec_size)
   );

   assign state_o = state;

   // Bus wait tracking: limit fires on the cycle the count would reach BUS_TIMEOUT, unless ready arrives
   always_comb begin
      req_pending = (state == ST_FETCH) || ((state == ST_MEM) && DATA_WAIT);
      req_ready   = (state == ST_FETCH) ? i_ready : d_ready;
      limit_hit   = (BUS_TIMEOUT != 0) && req_pending && !req_ready &&
                    (int'(cnt) + 1 == BUS_TIMEOUT);
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_FETCH;
      else        state <= nxt;
   end

   // Wait counter restarts on every state change and on ready
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                         cnt <= '0;
      else if ((nxt != state) || !req_pending || req_ready) cnt <= '0;
      else                                                cnt <= cnt + CW'(1);
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         illegal_instr <= 1'b0;
         bus_err       <= 1'b0;
      end else begin
         if ((state == ST_DECODE) && !dec_legal) illegal_instr <= 1'b1;
         if (limit_hit)                          bus_err       <= 1'b1;
      end
   end

   // Next state plus per-state strobes; decode selects only leave the block in DECODE..WB
   always_comb begin
      nxt           = state;
      i_req         = 1'b0;
      ir_we         = 1'b0;
      d_req         = 1'b0;
      d_we          = 1'b0;
      regfile_we    = 1'b0;
      pc_we         = 1'b0;
      branch        = 1'b0;
      jal           = 1'b0;
      instr_retired = 1'b0;
      alu_src_sel_1 = 1'b0;
      alu_src_sel_2 = 1'b0;
      reg_w_src_sel = 2'b00;
      alu_control   = 4'b0000;
      size_control  = 3'b000;
      if (state inside {ST_DECODE, ST_EXECUTE, ST_MEM, ST_WB}) begin
         alu_src_sel_1 = dec_sel_1;
         alu_src_sel_2 = dec_sel_2;
         reg_w_src_sel = dec_wsrc;
         alu_control   = dec_alu;
         size_control  = dec_size;
      end
      case (state)
         ST_FETCH: begin
            i_req = 1'b1;
            if (limit_hit) nxt = ST_TRAP;
            else if (i_ready) begin
               ir_we = 1'b1;
               nxt   = ST_DECODE;
            end
         end
         ST_DECODE: nxt = dec_legal ? ST_EXECUTE : ST_TRAP;
         ST_EXECUTE: begin
            case (dec_cls)
               CL_B: begin
                  branch        = 1'b1;
                  instr_retired = 1'b1;
                  // taken loads the branch target, not-taken loads PC+4; the PC mux keys on btaken
                  if (btaken) pc_we = 1'b1;
                  else        pc_we = 1'b1;
                  nxt = ST_FETCH;
               end
               CL_IL, CL_S: nxt = ST_MEM;
               default:     nxt = ST_WB;
            endcase
         end
         ST_MEM: begin
            d_req = 1'b1;
            d_we  = (dec_cls == CL_S);
            if (limit_hit) nxt = ST_TRAP;
            else if (!DATA_WAIT || d_ready) begin
               if (dec_cls == CL_S) begin
                  pc_we         = 1'b1;
                  instr_retired = 1'b1;
                  nxt           = ST_FETCH;
               end else begin
                  nxt = ST_WB;
               end
            end
         end
         ST_WB: begin
            regfile_we    = 1'b1;
            instr_retired = 1'b1;
            pc_we         = 1'b1;
            jal           = (dec_cls == CL_JAL) || (dec_cls == CL_JALR);
            nxt           = ST_FETCH;
         end
         ST_TRAP: nxt = ST_TRAP;
         default: nxt = ST_FETCH;
      endcase
      // the fetch request is held off while reset is asserted
      if (!reset) begin
         i_req = 1'b0;
         ir_we = 1'b0;
      end
   end

endmodule

// File: tb/tb_rv32i_mc_control_unit.sv
// tb/tb_rv32i_mc_control_unit.sv - scoreboard bench for the multi-cycle control unit
module tb_rv32i_mc_control_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr_code = 32'h0;
   logic        i_ready = 1'b0, d_ready = 1'b0, btaken = 1'b0;
   logic        i_req, ir_we, d_req, d_we, regfile_we, pc_we;
   logic        alu_src_sel_1, alu_src_sel_2, branch, jal;
   logic        instr_retired, illegal_instr, bus_err;
   logic [1:0]  reg_w_src_sel;
   logic [3:0]  alu_control;
   logic [2:0]  size_control, state_o;

   localparam int CL_PLAIN = 0, CL_LOAD = 1, CL_STORE = 2, CL_BR = 3, CL_JMP = 4, CL_BAD = 5;

   typedef struct packed {
      logic [2:0] st;
      logic i_req, ir_we, d_req, d_we, rf_we, pc_we, br, jal, ret, ill, berr, s1, s2;
      logic [1:0] rw;
      logic [3:0] alu;
      logic [2:0] sz;
   } obs_t;

   typedef struct packed {
      logic ir;
      logic dr;
      obs_t exp;
   } step_t;

   step_t sb[$];
   int    n_pass = 0;
   int    n_total = 0;

   always #5 clk = ~clk;

   rv32i_mc_control_unit #(.BUS_TIMEOUT(16), .DATA_WAIT(1'b1)) dut (
      .clk           (clk),
      .reset         (reset),
      .instr_code    (instr_code),
      .i_ready       (i_ready),
      .d_ready       (d_ready),
      .btaken        (btaken),
      .i_req         (i_req),
      .ir_we         (ir_we),
      .d_req         (d_req),
      .d_we          (d_we),
      .regfile_we    (regfile_we),
      .pc_we         (pc_we),
      .alu_src_sel_1 (alu_src_sel_1),
      .alu_src_sel_2 (alu_src_sel_2),
      .reg_w_src_sel (reg_w_src_sel),
      .alu_control   (alu_control),
      .size_control  (size_control),
      .branch        (branch),
      .jal           (jal),
      .instr_retired (instr_retired),
      .illegal_instr (illegal_instr),
      .bus_err       (bus_err),
      .state_o       (state_o)
   );

   function automatic obs_t observe();
      obs_t o;
      o.st = state_o;   o.i_req = i_req;   o.ir_we = ir_we;   o.d_req = d_req;
      o.d_we = d_we;    o.rf_we = regfile_we; o.pc_we = pc_we; o.br = branch;
      o.jal = jal;      o.ret = instr_retired; o.ill = illegal_instr; o.berr = bus_err;
      o.s1 = alu_src_sel_1; o.s2 = alu_src_sel_2; o.rw = reg_w_src_sel;
      o.alu = alu_control;  o.sz = size_control;
      return o;
   endfunction

   task automatic chk(input string tag, input obs_t got, input obs_t exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
   endtask

   task automatic push(input logic ir, input logic dr, input obs_t e);
      step_t s;
      s.ir = ir; s.dr = dr; s.exp = e;
      sb.push_back(s);
   endtask

   // expected per-cycle trace for one instruction, derived from the state paths
   task automatic plan(input int cls, input logic s1, input logic s2, input logic [1:0] rw,
                       input logic [3:0] alu, input logic [2:0] sz,
                       input int iw, input int dw, input bit partial);
      obs_t sel, e;
      sel = '0; sel.s1 = s1; sel.s2 = s2; sel.rw = rw; sel.alu = alu; sel.sz = sz;
      if (iw >= 16) begin
         for (int i = 0; i < 16; i++) begin
            e = '0; e.i_req = 1'b1; push(1'b0, 1'b0, e);
         end
         for (int i = 0; i < 3; i++) begin
            e = '0; e.st = 3'd5; e.berr = 1'b1; push(1'b0, 1'b0, e);
         end
         return;
      end
      for (int i = 0; i < iw; i++) begin
         e = '0; e.i_req = 1'b1; push(1'b0, 1'b0, e);
      end
      e = '0; e.i_req = 1'b1; e.ir_we = 1'b1; push(1'b1, 1'b0, e);
      e = sel; e.st = 3'd1; push(1'b0, 1'b0, e);
      if (cls == CL_BAD) begin
         for (int i = 0; i < 4; i++) begin
            e = '0; e.st = 3'd5; e.ill = 1'b1; push(1'b0, 1'b0, e);
         end
         return;
      end
      e = sel; e.st = 3'd2;
      if (cls == CL_BR) begin
         e.br = 1'b1; e.pc_we = 1'b1; e.ret = 1'b1; push(1'b0, 1'b0, e);
         return;
      end
      push(1'b0, 1'b0, e);
      if (cls == CL_LOAD || cls == CL_STORE) begin
         for (int i = 0; i < dw; i++) begin
            e = sel; e.st = 3'd3; e.d_req = 1'b1; e.d_we = (cls == CL_STORE);
            push(1'b0, 1'b0, e);
         end
         if (partial) return;
         e = sel; e.st = 3'd3; e.d_req = 1'b1; e.d_we = (cls == CL_STORE);
         if (cls == CL_STORE) begin
            e.pc_we = 1'b1; e.ret = 1'b1; push(1'b0, 1'b1, e);
            return;
         end
         push(1'b0, 1'b1, e);
      end
      e = sel; e.st = 3'd4; e.rf_we = 1'b1; e.ret = 1'b1; e.pc_we = 1'b1;
      e.jal = (cls == CL_JMP);
      push(1'b0, 1'b0, e);
   endtask

   // replay the queued trace: drive ready inputs at the falling edge, compare 1 ns later
   task automatic drain(input string tag);
      step_t s;
      while (sb.size() > 0) begin
         s = sb.pop_front();
         i_ready = s.ir;
         d_ready = s.dr;
         #1;
         chk(tag, observe(), s.exp);
         @(negedge clk);
      end
      i_ready = 1'b0;
      d_ready = 1'b0;
   endtask

   task automatic run(input string tag, input logic [31:0] ins, input int cls,
                      input logic s1, input logic s2, input logic [1:0] rw,
                      input logic [3:0] alu, input logic [2:0] sz,
                      input int iw, input int dw);
      instr_code = ins;
      plan(cls, s1, s2, rw, alu, sz, iw, dw, 1'b0);
      drain(tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      chk(tag, observe(), '0);
      @(negedge clk);
      #1;
      chk(tag, observe(), '0);
      reset = 1'b1;
   endtask

   initial begin
      obs_t e;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_state", observe(), '0);
      @(negedge clk);
      reset = 1'b1;

      run("add",   32'h002081B3, CL_PLAIN, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000, 0, 0);
      run("lw",    32'h0040A183, CL_LOAD,  1'b0, 1'b1, 2'b01, 4'b0000, 3'b010, 2, 3);
      run("sw",    32'h0020A223, CL_STORE, 1'b0, 1'b1, 2'b00, 4'b0000, 3'b010, 0, 0);
      btaken = 1'b1;
      run("beq_t", 32'h00208463, CL_BR,    1'b0, 1'b0, 2'b00, 4'b1000, 3'b000, 0, 0);
      btaken = 1'b0;
      run("beq_n", 32'h00208463, CL_BR,    1'b0, 1'b0, 2'b00, 4'b1000, 3'b000, 0, 0);
      run("jal",   32'h010000EF, CL_JMP,   1'b1, 1'b1, 2'b11, 4'b0000, 3'b000, 0, 0);
      run("jalr",  32'h000080E7, CL_JMP,   1'b0, 1'b1, 2'b11, 4'b0000, 3'b000, 1, 0);
      run("lui",   32'h123450B7, CL_PLAIN, 1'b0, 1'b1, 2'b10, 4'b0000, 3'b000, 0, 0);
      run("auipc", 32'h00001097, CL_PLAIN, 1'b1, 1'b1, 2'b00, 4'b0000, 3'b000, 0, 0);
      run("srai",  32'h4010D093, CL_PLAIN, 1'b0, 1'b1, 2'b00, 4'b1101, 3'b000, 0, 0);
      run("sub",   32'h40208133, CL_PLAIN, 1'b0, 1'b0, 2'b00, 4'b1000, 3'b000, 0, 0);
      run("sw_wait", 32'h0020A223, CL_STORE, 1'b0, 1'b1, 2'b00, 4'b0000, 3'b010, 0, 2);
      run("ifetch_15w", 32'h002081B3, CL_PLAIN, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000, 15, 0);

      run("illegal", 32'h00000000, CL_BAD, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000, 0, 0);
      do_reset("illegal_reset");

      run("timeout", 32'h002081B3, CL_PLAIN, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000, 16, 0);
      do_reset("timeout_reset");

      instr_code = 32'h0040A183;
      plan(CL_LOAD, 1'b0, 1'b1, 2'b01, 4'b0000, 3'b010, 0, 2, 1'b1);
      drain("lw_abort");
      #1;
      e = '0; e.st = 3'd3; e.d_req = 1'b1; e.s2 = 1'b1; e.rw = 2'b01; e.sz = 3'b010;
      chk("mem_hold", observe(), e);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_mem_reset", observe(), '0);
      @(negedge clk);
      reset = 1'b1;

      run("recover", 32'h002081B3, CL_PLAIN, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
